fpu_host_if: RTL and testbench
==============================

# fpu_host_if

Bus-side command issuer for the `fpu` core: the initiator end of the FPU's start/cmd_end/busy handshake. An 8-bit CPU port writes operands and an opcode into byte registers and writes a go bit. The block then drives the FPU through one command, captures the 32-bit result and raises a done status and an optional interrupt. It sits between the CPU's peripheral bus decode and the `fpu` instance.

## Interface
- TIMEOUT_CYCLES, 1024, watchdog limit in clk cycles from start assertion (used only with FPU_TIMEOUT_EN)
- clk  in  1  system clock
- arst  in  1  asynchronous active-high reset
- cs  in  1  chip select
- wr  in  1  write strobe, sampled on clk when cs=1
- rd  in  1  read enable
- addr  in  4  register offset
- data_in  in  8  write data
- data_out  out  8  read data, combinational; 0 when !(cs&rd)
- irq  out  1  level interrupt = done & irq_en
- fpu_start  out  1  command request to fpu
- fpu_a_operand  out  32  operand A register
- fpu_b_operand  out  32  operand B register
- fpu_operation  out  pa_fpu::e_fpu_op  opcode register
- fpu_result  in  32  fpu ieee_packet_out
- fpu_cmd_end  in  1  fpu end of command
- fpu_busy  in  1  fpu operation in progress

## Operation
- Register map (little-endian bytes):
  - 0x0–0x3 A[7:0]..A[31:24] (RW)
  - 0x4–0x7 B (RW)
  - 0x8 OP, low $bits(e_fpu_op) bits (RW)
  - 0x9 CTRL: bit0 go (write-only, reads 0), bit1 irq_en (RW)
  - 0xA STATUS: bit0 busy, bit1 done (W1C), bit2 timeout_err (W1C)
  - 0xC–0xF RESULT (RO)
  - Unmapped offsets read 0 and ignore writes.
- FSM states and transitions:
  - IDLE: go=1 → ISSUE.
  - ISSUE: fpu_start=1 until fpu_cmd_end is sampled high; on that edge RESULT<=fpu_result, done<=1 → DRAIN.
  - DRAIN: fpu_start=0; wait for fpu_busy=0 → IDLE.
- A go write clears done and timeout_err.
- STATUS.busy = (state != IDLE).
- While busy=1, writes to A/B/OP and go are ignored. irq_en and the W1C bits remain writable.
- Same-cycle W1C of done and the capture edge: set wins.
- Reset values: all registers 0, state IDLE, fpu_start=0, irq=0, data_out=0.
- Reset mid-operation: fpu_start drops asynchronously and RESULT clears. The fpu shares arst.

## Timing
- Go write at edge N → fpu_start=1 after edge N. Operands are stable from the register outputs for the whole command.
- cmd_end sampled high at edge M → RESULT valid, done=1 and fpu_start=0 after edge M. irq follows the same cycle if irq_en=1.
- Earliest re-issue: the edge after the one where fpu_busy is sampled low in DRAIN.
- Back-to-back go: a second go while busy is dropped and has no queued effect.

## Configuration
- FPU_TIMEOUT_EN defined:
  - A counter runs in ISSUE.
  - When it reaches TIMEOUT_CYCLES without cmd_end: timeout_err<=1, done<=1, fpu_start<=0, RESULT unchanged, then → DRAIN.
- FPU_TIMEOUT_EN undefined:
  - No counter is built.
  - STATUS bit2 reads 0 and ISSUE waits indefinitely.

## Structure
- Add to pa_fpu:
  - register offset localparams
  - CTRL/STATUS bit index localparams
  - e_fpu_host_state enum {IDLE, ISSUE, DRAIN}
- Sub-module fpu_watchdog (counter with clear/enable/expired), instantiated only under FPU_TIMEOUT_EN.

## Test plan
- A=0x3e800000, B=0x3f000000, OP=op_mul, go → RESULT reads 0x3e000000, done=1, busy=0.
- A=0x41800000, B=0x42000000, op_mul, irq_en=1 → RESULT=0x44000000, irq high until done W1C; after 0x02 to 0xA, irq=0.
- During ISSUE, write 0xFF to 0x0 and a second go → A readback unchanged; exactly one fpu_start rising edge.
- FPU_TIMEOUT_EN, TIMEOUT_CYCLES=16, fpu_cmd_end tied 0 → after 16 cycles in ISSUE STATUS=0x06, fpu_start=0, RESULT=0.
- Assert arst while in ISSUE → fpu_start=0 immediately; all registers read 0 after release.
- A=0x3f800000, B=0x3f8ccccd, op_mul, then a go with OP unchanged → both results 0x3f8ccccd; done cleared at the second go and set again at the second capture.

Source files
------------

// File: rtl/pa_fpu.sv
// Shared FPU definitions: opcode enum plus the host-interface register map,
// control/status bit positions and issuer FSM states.
package pa_fpu;

    typedef enum logic [2:0] {
        op_add  = 3'd0,
        op_sub  = 3'd1,
        op_mul  = 3'd2,
        op_div  = 3'd3,
        op_sqrt = 3'd4
    } e_fpu_op;

    localparam logic [3:0] REG_A0     = 4'h0;
    localparam logic [3:0] REG_A3     = 4'h3;
    localparam logic [3:0] REG_B0     = 4'h4;
    localparam logic [3:0] REG_B3     = 4'h7;
    localparam logic [3:0] REG_OP     = 4'h8;
    localparam logic [3:0] REG_CTRL   = 4'h9;
    localparam logic [3:0] REG_STATUS = 4'hA;
    localparam logic [3:0] REG_RES0   = 4'hC;
    localparam logic [3:0] REG_RES3   = 4'hF;

    localparam int CTRL_GO        = 0;
    localparam int CTRL_IRQ_EN    = 1;
    localparam int STATUS_BUSY    = 0;
    localparam int STATUS_DONE    = 1;
    localparam int STATUS_TIMEOUT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } e_fpu_host_state;

    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
        return word[idx*8 +: 8];
    endfunction

endpackage

// File: rtl/fpu_host_if_watchdog.sv
// Cycle watchdog for the FPU issuer: counts while enabled, flags once LIMIT
// cycles have elapsed. Only built when FPU_TIMEOUT_EN is defined.
module fpu_watchdog #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic arst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count_r;

    // Elapsed-cycle counter; saturates at the limit so expired stays asserted
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            count_r <= {W{1'b0}};
        end else if (clear) begin
            count_r <= {W{1'b0}};
        end else if (enable && !expired) begin
            count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign expired = enable && (count_r == W'(LIMIT - 1));

endmodule

// File: rtl/fpu_host_if.sv
// Byte-wide CPU register port that issues one command at a time to the fpu core.
// Define FPU_TIMEOUT_EN to build the ISSUE-state watchdog and STATUS.timeout_err.
module fpu_host_if
    import pa_fpu::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        cs,
    input  logic        wr,
    input  logic        rd,
    input  logic [3:0]  addr,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        irq,
    output logic        fpu_start,
    output logic [31:0] fpu_a_operand,
    output logic [31:0] fpu_b_operand,
    output e_fpu_op     fpu_operation,
    input  logic [31:0] fpu_result,
    input  logic        fpu_cmd_end,
    input  logic        fpu_busy
);

    localparam int OP_W = $bits(e_fpu_op);

    e_fpu_host_state state_r;
    logic [31:0]     a_r;
    logic [31:0]     b_r;
    e_fpu_op         op_r;
    logic            irq_en_r;
    logic            done_r;
    logic            timeout_err_r;
    logic [31:0]     result_r;
    logic            start_r;

    logic            wr_en_s;
    logic            busy_s;
    logic            go_s;
    logic            w1c_done_s;
    logic            w1c_timeout_s;
    logic            wd_expired_s;
    logic [7:0]      rdata_s;

    assign wr_en_s       = cs && wr;
    assign busy_s        = (state_r != IDLE);
    assign go_s          = wr_en_s && (addr == REG_CTRL) && data_in[CTRL_GO] && !busy_s;
    assign w1c_done_s    = wr_en_s && (addr == REG_STATUS) && data_in[STATUS_DONE];
    assign w1c_timeout_s = wr_en_s && (addr == REG_STATUS) && data_in[STATUS_TIMEOUT];

`ifdef FPU_TIMEOUT_EN
    fpu_watchdog #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .arst    (arst),
        .clear   (state_r != ISSUE),
        .enable  (state_r == ISSUE),
        .expired (wd_expired_s)
    );
`else
    assign wd_expired_s = 1'b0;
`endif

    // Operand/opcode registers lock while a command is in flight; irq_en never does
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            a_r      <= 32'h0000_0000;
            b_r      <= 32'h0000_0000;
            op_r     <= op_add;
            irq_en_r <= 1'b0;
        end else if (wr_en_s) begin
            if (!busy_s) begin
                case (addr)
                    4'h0, 4'h1, 4'h2, 4'h3: a_r[addr[1:0]*8 +: 8] <= data_in;
                    4'h4, 4'h5, 4'h6, 4'h7: b_r[addr[1:0]*8 +: 8] <= data_in;
                    REG_OP:                 op_r <= e_fpu_op'(data_in[OP_W-1:0]);
                    default:                ;
                endcase
            end
            if (addr == REG_CTRL) begin
                irq_en_r <= data_in[CTRL_IRQ_EN];
            end
        end
    end

    // Issuer FSM; status set events are written last so they beat a same-cycle W1C
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_r       <= IDLE;
            start_r       <= 1'b0;
            done_r        <= 1'b0;
            timeout_err_r <= 1'b0;
            result_r      <= 32'h0000_0000;
        end else begin
            if (w1c_done_s) begin
                done_r <= 1'b0;
            end
            if (w1c_timeout_s) begin
                timeout_err_r <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (go_s) begin
                        done_r        <= 1'b0;
                        timeout_err_r <= 1'b0;
                        start_r       <= 1'b1;
                        state_r       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (fpu_cmd_end) begin
                        result_r <= fpu_result;
                        done_r   <= 1'b1;
                        start_r  <= 1'b0;
                        state_r  <= DRAIN;
                    end else if (wd_expired_s) begin
                        timeout_err_r <= 1'b1;
                        done_r        <= 1'b1;
                        start_r       <= 1'b0;
                        state_r       <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!fpu_busy) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    start_r <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Read-data mux; go is write-only and reads back as zero
    always_comb begin
        rdata_s = 8'h00;
        if (cs && rd) begin
            case (addr)
                4'h0, 4'h1, 4'h2, 4'h3: rdata_s = byte_sel(a_r, addr[1:0]);
                4'h4, 4'h5, 4'h6, 4'h7: rdata_s = byte_sel(b_r, addr[1:0]);
                REG_OP:                 rdata_s = {{(8-OP_W){1'b0}}, op_r};
                REG_CTRL:               rdata_s = {6'b000000, irq_en_r, 1'b0};
                REG_STATUS:             rdata_s = {5'b00000, timeout_err_r, done_r, busy_s};
                4'hC, 4'hD, 4'hE, 4'hF: rdata_s = byte_sel(result_r, addr[1:0]);
                default:                rdata_s = 8'h00;
            endcase
        end else begin
            rdata_s = 8'h00;
        end
    end

    assign data_out      = rdata_s;
    assign irq           = done_r && irq_en_r;
    assign fpu_start     = start_r;
    assign fpu_a_operand = a_r;
    assign fpu_b_operand = b_r;
    assign fpu_operation = op_r;

endmodule

// File: tb/tb_fpu_host_if.sv
// Directed bench for fpu_host_if with a small behavioural fpu responder.
module tb_fpu_host_if;
    import pa_fpu::*;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        cs = 1'b0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [3:0]  addr = 4'h0;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  data_out;
    logic        irq;
    logic        fpu_start;
    logic [31:0] fpu_a_operand;
    logic [31:0] fpu_b_operand;
    e_fpu_op     fpu_operation;
    logic [31:0] fpu_result = 32'h0;
    logic        fpu_cmd_end = 1'b0;
    logic        fpu_busy = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int start_rises = 0;
    logic start_prev = 1'b0;
    bit hang = 1'b0;
    int ph = 0;

    fpu_host_if #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .arst(arst), .cs(cs), .wr(wr), .rd(rd), .addr(addr),
        .data_in(data_in), .data_out(data_out), .irq(irq), .fpu_start(fpu_start),
        .fpu_a_operand(fpu_a_operand), .fpu_b_operand(fpu_b_operand),
        .fpu_operation(fpu_operation), .fpu_result(fpu_result),
        .fpu_cmd_end(fpu_cmd_end), .fpu_busy(fpu_busy)
    );

    always #5 clk = ~clk;

    // Hand-computed products for the operand pairs used below
    function automatic logic [31:0] fpu_calc(input logic [31:0] a, input logic [31:0] b, input e_fpu_op op);
        if (op != op_mul) return 32'hBADBAD00;
        case ({a, b})
            {32'h3e800000, 32'h3f000000}: return 32'h3e000000;
            {32'h41800000, 32'h42000000}: return 32'h44000000;
            {32'h3f800000, 32'h3f8ccccd}: return 32'h3f8ccccd;
            default:                      return 32'hDEADBEEF;
        endcase
    endfunction

    // fpu responder: busy on start, cmd_end pulse after a few cycles, busy drops later
    always @(negedge clk) begin
        if (fpu_start && !start_prev) start_rises = start_rises + 1;
        start_prev = fpu_start;
        if (arst) begin
            ph = 0; fpu_busy = 1'b0; fpu_cmd_end = 1'b0;
        end else begin
            case (ph)
                0: if (fpu_start && !hang) begin fpu_busy = 1'b1; ph = 1; end
                6: begin fpu_cmd_end = 1'b1; fpu_result = fpu_calc(fpu_a_operand, fpu_b_operand, fpu_operation); ph = 7; end
                7: begin fpu_cmd_end = 1'b0; fpu_result = 32'h0; ph = 8; end
                8: begin fpu_busy = 1'b0; ph = 0; end
                default: ph = ph + 1;
            endcase
        end
    end

    task automatic bus_wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk); cs = 1'b1; wr = 1'b1; addr = a; data_in = d;
        @(negedge clk); cs = 1'b0; wr = 1'b0; addr = 4'h0; data_in = 8'h00;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk); cs = 1'b1; rd = 1'b1; addr = a;
        #1 d = data_out; cs = 1'b0; rd = 1'b0;
    endtask

    task automatic wr_word(input logic [3:0] base, input logic [31:0] w);
        for (int i = 0; i < 4; i++) bus_wr(base + 4'(i), w[i*8 +: 8]);
    endtask

    task automatic rd_word(input logic [3:0] base, output logic [31:0] w);
        logic [7:0] d;
        for (int i = 0; i < 4; i++) begin bus_rd(base + 4'(i), d); w[i*8 +: 8] = d; end
    endtask

    task automatic wait_idle(output bit ok);
        logic [7:0] s;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            bus_rd(REG_STATUS, s);
            if (!s[0]) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        #1;
        n_checks++; if (fpu_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b expected 0", fpu_start); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
        repeat (3) @(negedge clk);
        arst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus_rd(4'(i), d);
            n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL reset_reg[%0h]: got %h expected 00", i, d); end
        end
    endtask

    task automatic test_mul_basic();
        logic [31:0] w; logic [7:0] d; bit ok;
        wr_word(REG_A0, 32'h3e800000);
        wr_word(REG_B0, 32'h3f000000);
        bus_wr(REG_OP, 8'h02);
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL idle_data_out: got %h expected 00", data_out); end
        bus_wr(REG_CTRL, 8'h01);
        n_checks++; if (fpu_start !== 1'b1) begin n_fail++; $display("FAIL go_start: got %b expected 1", fpu_start); end
        n_checks++; if (fpu_a_operand !== 32'h3e800000) begin n_fail++; $display("FAIL a_operand: got %h expected 3e800000", fpu_a_operand); end
        n_checks++; if (fpu_b_operand !== 32'h3f000000) begin n_fail++; $display("FAIL b_operand: got %h expected 3f000000", fpu_b_operand); end
        n_checks++; if (fpu_operation !== op_mul) begin n_fail++; $display("FAIL operation: got %0d expected %0d", fpu_operation, op_mul); end
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL mul_wait: got busy expected idle"); end
        rd_word(REG_RES0, w);
        n_checks++; if (w !== 32'h3e000000) begin n_fail++; $display("FAIL mul_result: got %h expected 3e000000", w); end
        bus_rd(REG_STATUS, d);
        n_checks++; if (d !== 8'h02) begin n_fail++; $display("FAIL mul_status: got %h expected 02", d); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL mul_irq: got %b expected 0", irq); end
    endtask

    task automatic test_irq();
        logic [31:0] w; logic [7:0] d; bit ok;
        bus_wr(REG_CTRL, 8'h02);
        wr_word(REG_A0, 32'h41800000);
        wr_word(REG_B0, 32'h42000000);
        bus_wr(REG_CTRL, 8'h03);
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL irq_wait: got busy expected idle"); end
        rd_word(REG_RES0, w);
        n_checks++; if (w !== 32'h44000000) begin n_fail++; $display("FAIL irq_result: got %h expected 44000000", w); end
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b expected 1", irq); end
        bus_rd(REG_CTRL, d);
        n_checks++; if (d !== 8'h02) begin n_fail++; $display("FAIL ctrl_read: got %h expected 02", d); end
        bus_wr(REG_STATUS, 8'h02);
        #1;
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b expected 0", irq); end
        bus_rd(REG_STATUS, d);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL w1c_status: got %h expected 00", d); end
        bus_wr(REG_CTRL, 8'h00);
    endtask

    task automatic test_back_to_back();
        logic [31:0] w; logic [7:0] d; bit ok; int rises0;
        wr_word(REG_A0, 32'h3f800000);
        wr_word(REG_B0, 32'h3f8ccccd);
        rises0 = start_rises;
        bus_wr(REG_CTRL, 8'h01);
        bus_wr(REG_A0, 8'hFF);
        bus_wr(REG_CTRL, 8'h01);
        bus_rd(REG_STATUS, d);
        n_checks++; if (d !== 8'h01) begin n_fail++; $display("FAIL issue_status: got %h expected 01", d); end
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_wait: got busy expected idle"); end
        rd_word(REG_A0, w);
        n_checks++; if (w !== 32'h3f800000) begin n_fail++; $display("FAIL locked_a: got %h expected 3f800000", w); end
        rd_word(REG_RES0, w);
        n_checks++; if (w !== 32'h3f8ccccd) begin n_fail++; $display("FAIL first_result: got %h expected 3f8ccccd", w); end
        repeat (4) @(negedge clk);
        n_checks++; if (start_rises - rises0 !== 1) begin n_fail++; $display("FAIL one_start: got %0d expected 1", start_rises - rises0); end
        bus_wr(REG_CTRL, 8'h01);
        bus_rd(REG_STATUS, d);
        n_checks++; if (d !== 8'h01) begin n_fail++; $display("FAIL go_clears_done: got %h expected 01", d); end
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL reissue_wait: got busy expected idle"); end
        rd_word(REG_RES0, w);
        n_checks++; if (w !== 32'h3f8ccccd) begin n_fail++; $display("FAIL second_result: got %h expected 3f8ccccd", w); end
        bus_rd(REG_STATUS, d);
        n_checks++; if (d !== 8'h02) begin n_fail++; $display("FAIL second_done: got %h expected 02", d); end
        repeat (2) @(negedge clk);
        n_checks++; if (start_rises - rises0 !== 2) begin n_fail++; $display("FAIL two_starts: got %0d expected 2", start_rises - rises0); end
    endtask

    task automatic test_arst_mid();
        logic [7:0] d;
        bus_wr(REG_CTRL, 8'h03);
        n_checks++; if (fpu_start !== 1'b1) begin n_fail++; $display("FAIL pre_arst_start: got %b expected 1", fpu_start); end
        #2 arst = 1'b1;
        #1;
        n_checks++; if (fpu_start !== 1'b0) begin n_fail++; $display("FAIL arst_start: got %b expected 0", fpu_start); end
        repeat (2) @(negedge clk);
        arst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus_rd(4'(i), d);
            n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL arst_reg[%0h]: got %h expected 00", i, d); end
        end
    endtask

`ifdef FPU_TIMEOUT_EN
    task automatic test_timeout();
        logic [31:0] w; logic [7:0] d; int cyc;
        hang = 1'b1;
        bus_wr(REG_CTRL, 8'h01);
        cyc = 0;
        while (fpu_start && cyc < 100) begin cyc++; @(negedge clk); end
        n_checks++; if (cyc !== 16) begin n_fail++; $display("FAIL timeout_cycles: got %0d expected 16", cyc); end
        bus_rd(REG_STATUS, d);
        n_checks++; if (d !== 8'h06) begin n_fail++; $display("FAIL timeout_status: got %h expected 06", d); end
        rd_word(REG_RES0, w);
        n_checks++; if (w !== 32'h0) begin n_fail++; $display("FAIL timeout_result: got %h expected 00000000", w); end
        bus_wr(REG_STATUS, 8'h06);
        bus_rd(REG_STATUS, d);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL timeout_w1c: got %h expected 00", d); end
        hang = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_mul_basic();
        test_irq();
        test_back_to_back();
        test_arst_mid();
`ifdef FPU_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion expected $finish");
        $fatal(1, "bench time limit");
    end

endmodule
